// File: rtl/rv32i_dec_exec_mem_if.sv
// Decode/execute bus: fetch-side inputs, register-file and write-back outputs.
interface rv32i_dec_exec_mem_if;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] srcreg1_data;
  logic [31:0] srcreg2_data;
  logic [4:0]  srcreg1_num;
  logic [4:0]  srcreg2_num;
  logic [4:0]  dstreg_num;
  logic        reg_we;
  logic        is_load;
  logic        is_store;
  logic        is_halt;
  logic [31:0] alu_result;
  logic [31:0] npc;
  logic [31:0] r_data;
  logic        halted;

  modport master (
    output ir, pc, srcreg1_data, srcreg2_data,
    input  srcreg1_num, srcreg2_num, dstreg_num, reg_we, is_load, is_store,
    input  is_halt, alu_result, npc, r_data, halted
  );

  modport slave (
    input  ir, pc, srcreg1_data, srcreg2_data,
    output srcreg1_num, srcreg2_num, dstreg_num, reg_we, is_load, is_store,
    output is_halt, alu_result, npc, r_data, halted
  );
endinterface

// File: rtl/rv32i_dec_exec_mem.sv
// Single-cycle RV32I decode/execute with byte-addressed data memory and sticky halt.
// Data memory starts zeroed.
module rv32i_dec_exec_mem #(
  parameter int unsigned DMEM_WORDS = 16384
) (
  input logic                 clk,
  input logic                 rst,
  rv32i_dec_exec_mem_if.slave bus
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  logic          halted_q;
  logic [31:0]   mem_q [DMEM_WORDS];

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]   pc4;
  logic [31:0]   op1, op2, alu_res;
  logic [4:0]    shamt;
  alu_op_e       alu_op;
  logic          br_taken;
  logic          reg_we_c, is_load_c, is_store_c, is_sys_c;
  logic [31:0]   npc_c;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   rdata_c;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_data;
  logic          store_en;

  assign opcode = bus.ir[6:0];
  assign funct3 = bus.ir[14:12];
  assign pc4    = bus.pc + 32'd4;

  assign imm_i = {{20{bus.ir[31]}}, bus.ir[31:20]};
  assign imm_s = {{20{bus.ir[31]}}, bus.ir[31:25], bus.ir[11:7]};
  assign imm_b = {{20{bus.ir[31]}}, bus.ir[7], bus.ir[30:25], bus.ir[11:8], 1'b0};
  assign imm_u = {bus.ir[31:12], 12'b0};
  assign imm_j = {{12{bus.ir[31]}}, bus.ir[19:12], bus.ir[20], bus.ir[30:21], 1'b0};

  // Only OP uses ir[30] for SUB; both OP and OP-IMM use it to pick arithmetic shift.
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic sub, input logic sra);
    alu_op_e op;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin : branch_cmp
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (bus.srcreg1_data == bus.srcreg2_data);
      3'b001:  br_taken = (bus.srcreg1_data != bus.srcreg2_data);
      3'b100:  br_taken = ($signed(bus.srcreg1_data) <  $signed(bus.srcreg2_data));
      3'b101:  br_taken = ($signed(bus.srcreg1_data) >= $signed(bus.srcreg2_data));
      3'b110:  br_taken = (bus.srcreg1_data <  bus.srcreg2_data);
      3'b111:  br_taken = (bus.srcreg1_data >= bus.srcreg2_data);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin : decode
    op1        = bus.srcreg1_data;
    op2        = bus.srcreg2_data;
    alu_op     = ALU_ADD;
    reg_we_c   = 1'b0;
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    is_sys_c   = 1'b0;
    npc_c      = pc4;
    case (opcode)
      OP_LUI:    begin op1 = 32'd0;  op2 = imm_u; reg_we_c = 1'b1; end
      OP_AUIPC:  begin op1 = bus.pc; op2 = imm_u; reg_we_c = 1'b1; end
      OP_JAL: begin
        op1 = bus.pc; op2 = 32'd4; reg_we_c = 1'b1;
        npc_c = bus.pc + imm_j;
      end
      OP_JALR: begin
        op1 = bus.pc; op2 = 32'd4; reg_we_c = 1'b1;
        npc_c = (bus.srcreg1_data + imm_i) & 32'hFFFF_FFFE;
      end
      OP_BRANCH: if (br_taken) npc_c = bus.pc + imm_b;
      OP_LOAD:   begin op2 = imm_i; is_load_c = 1'b1; reg_we_c = 1'b1; end
      OP_STORE:  begin op2 = imm_s; is_store_c = 1'b1; end
      OP_OPIMM: begin
        op2 = imm_i; reg_we_c = 1'b1;
        alu_op = alu_sel(funct3, 1'b0, bus.ir[30]);
      end
      OP_OP: begin
        reg_we_c = 1'b1;
        alu_op = alu_sel(funct3, bus.ir[30], bus.ir[30]);
      end
      OP_SYSTEM: begin is_sys_c = 1'b1; npc_c = bus.pc; end
      default: ;
    endcase
    if (halted_q) begin
      reg_we_c = 1'b0;
      npc_c    = bus.pc;
    end
    if (bus.ir[11:7] == 5'd0) reg_we_c = 1'b0;
  end

  assign shamt = op2[4:0];

  always_comb begin : alu
    alu_res = op1 + op2;
    case (alu_op)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SLT:  alu_res = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_res = {31'd0, op1 < op2};
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SRL:  alu_res = op1 >> shamt;
      ALU_SRA:  alu_res = 32'($signed(op1) >>> shamt);
      ALU_OR:   alu_res = op1 | op2;
      ALU_AND:  alu_res = op1 & op2;
      default:  alu_res = op1 + op2;
    endcase
  end

  // Upper address bits beyond the array simply wrap.
  assign word_idx = alu_res[AW+1:2];
  assign rd_word  = mem_q[word_idx];
  assign ld_byte  = rd_word[{alu_res[1:0], 3'b000} +: 8];
  assign ld_half  = rd_word[{alu_res[1], 4'b0000} +: 16];

  always_comb begin : load_extend
    rdata_c = 32'd0;
    if (is_load_c) begin
      case (funct3)
        3'b000:  rdata_c = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  rdata_c = {24'd0, ld_byte};
        3'b001:  rdata_c = {{16{ld_half[15]}}, ld_half};
        3'b101:  rdata_c = {16'd0, ld_half};
        default: rdata_c = rd_word;
      endcase
    end
  end

  always_comb begin : store_lanes
    case (funct3[1:0])
      2'b00: begin
        wr_mask = 4'b0001 << alu_res[1:0];
        wr_data = {4{bus.srcreg2_data[7:0]}};
      end
      2'b01: begin
        wr_mask = alu_res[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.srcreg2_data[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_data = bus.srcreg2_data;
      end
    endcase
  end

  // Addresses outside the low 16 MB belong to MMIO and never touch the array.
  assign store_en = is_store_c && !halted_q && (alu_res[31:24] == 8'h00);

  always_ff @(posedge clk) begin
    if (store_en && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_q[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           halted_q <= 1'b0;
    else if (is_sys_c) halted_q <= 1'b1;
  end

  initial begin
    for (int unsigned i = 0; i < DMEM_WORDS; i++) mem_q[i] = 32'd0;
  end

  assign bus.srcreg1_num = bus.ir[19:15];
  assign bus.srcreg2_num = bus.ir[24:20];
  assign bus.dstreg_num  = bus.ir[11:7];
  assign bus.reg_we      = reg_we_c;
  assign bus.is_load     = is_load_c;
  assign bus.is_store    = is_store_c;
  assign bus.is_halt     = is_sys_c | halted_q;
  assign bus.alu_result  = alu_res;
  assign bus.npc         = npc_c;
  assign bus.r_data      = rdata_c;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_rv32i_dec_exec_mem.sv
// Randomized bench for rv32i_dec_exec_mem against an instruction-level reference model.
module tb_rv32i_dec_exec_mem;

  localparam int unsigned DMEM_WORDS = 16384;
  localparam logic [31:0] MASK = 32'(DMEM_WORDS * 4 - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_dec_exec_mem_if bus ();

  rv32i_dec_exec_mem #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        chk_alu;
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] rdata;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic        halted_m = 1'b0;
  logic [7:0]  mm [int unsigned];
  exp_t        p;
  logic [31:0] s_alu, s_npc, s_rdata;
  logic        s_we, s_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] rdb(input logic [31:0] a);
    int unsigned k = int'(a & MASK);
    return mm.exists(k) ? mm[k] : 8'h00;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] ea, input logic [2:0] f3);
    logic [31:0] w, wa, ha;
    logic [7:0]  b;
    logic [15:0] h;
    wa = ea & ~32'd3;
    ha = ea & ~32'd1;
    w  = {rdb(wa + 3), rdb(wa + 2), rdb(wa + 1), rdb(wa)};
    b  = rdb(ea);
    h  = {rdb(ha + 1), rdb(ha)};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] arith(input logic [2:0] f3, input logic [31:0] x,
                                        input logic [31:0] y, input logic alt);
    int unsigned sh = int'(y[4:0]);
    case (f3)
      3'd0:    return alt ? x - y : x + y;
      3'd1:    return x << sh;
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? 32'($signed(x) >>> sh) : x >> sh;
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic exp_t predict(input logic [31:0] ir_v, input logic [31:0] pc_v,
                                   input logic [31:0] a, input logic [31:0] b, input logic h);
    exp_t        e;
    logic [2:0]  f3 = ir_v[14:12];
    logic [31:0] ii, is_, ib, iu, ij;
    logic        tk;
    ii  = {{20{ir_v[31]}}, ir_v[31:20]};
    is_ = {{20{ir_v[31]}}, ir_v[31:25], ir_v[11:7]};
    ib  = {{19{ir_v[31]}}, ir_v[31], ir_v[7], ir_v[30:25], ir_v[11:8], 1'b0};
    iu  = {ir_v[31:12], 12'd0};
    ij  = {{11{ir_v[31]}}, ir_v[31], ir_v[19:12], ir_v[20], ir_v[30:21], 1'b0};
    e = '{default: '0};
    e.npc = pc_v + 32'd4;
    case (ir_v[6:0])
      7'h37: begin e.reg_we = 1; e.chk_alu = 1; e.alu = iu; end
      7'h17: begin e.reg_we = 1; e.chk_alu = 1; e.alu = pc_v + iu; end
      7'h6F: begin e.reg_we = 1; e.chk_alu = 1; e.alu = pc_v + 4; e.npc = pc_v + ij; end
      7'h67: begin e.reg_we = 1; e.chk_alu = 1; e.alu = pc_v + 4; e.npc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = !($signed(a) < $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = !(a < b);
          default: tk = 1'b0;
        endcase
        if (tk) e.npc = pc_v + ib;
      end
      7'h03: begin
        e.is_load = 1; e.reg_we = 1; e.chk_alu = 1;
        e.alu = a + ii; e.rdata = load_val(a + ii, f3);
      end
      7'h23: begin e.is_store = 1; e.chk_alu = 1; e.alu = a + is_; end
      7'h13: begin e.reg_we = 1; e.chk_alu = 1; e.alu = arith(f3, a, ii, (f3 == 3'd5) && ir_v[30]); end
      7'h33: begin e.reg_we = 1; e.chk_alu = 1; e.alu = arith(f3, a, b, ir_v[30]); end
      7'h73: begin e.is_halt = 1; e.npc = pc_v; end
      default: ;
    endcase
    if (h) begin e.reg_we = 0; e.npc = pc_v; e.is_halt = 1; end
    if (ir_v[11:7] == 5'd0) e.reg_we = 0;
    return e;
  endfunction

  task automatic commit(input logic [31:0] ir_v, input logic [31:0] b);
    logic [31:0] ea = p.alu;
    logic [31:0] base;
    if (p.is_store && !halted_m && ea[31:24] == 8'h00) begin
      case (ir_v[14:12])
        3'd0: mm[int'(ea & MASK)] = b[7:0];
        3'd1: begin
          base = ea & ~32'd1;
          mm[int'(base & MASK)]       = b[7:0];
          mm[int'((base + 1) & MASK)] = b[15:8];
        end
        default: begin
          base = ea & ~32'd3;
          for (int i = 0; i < 4; i++) mm[int'((base + 32'(i)) & MASK)] = b[i*8 +: 8];
        end
      endcase
    end
    if (p.is_halt) halted_m = 1'b1;
  endtask

  // One instruction per cycle: drive after the edge, check at the falling edge, update model at the edge.
  task automatic step(input logic [31:0] ir_v, input logic [31:0] pc_v,
                      input logic [31:0] a, input logic [31:0] b);
    bus.ir = ir_v; bus.pc = pc_v; bus.srcreg1_data = a; bus.srcreg2_data = b;
    @(negedge clk);
    p = predict(ir_v, pc_v, a, b, halted_m);
    chk("rs1_num",  32'(bus.srcreg1_num), 32'(ir_v[19:15]));
    chk("rs2_num",  32'(bus.srcreg2_num), 32'(ir_v[24:20]));
    chk("rd_num",   32'(bus.dstreg_num),  32'(ir_v[11:7]));
    chk("reg_we",   32'(bus.reg_we),      32'(p.reg_we));
    chk("is_load",  32'(bus.is_load),     32'(p.is_load));
    chk("is_store", 32'(bus.is_store),    32'(p.is_store));
    chk("is_halt",  32'(bus.is_halt),     32'(p.is_halt));
    chk("halted",   32'(bus.halted),      32'(halted_m));
    chk("npc",      bus.npc,              p.npc);
    chk("r_data",   bus.r_data,           p.rdata);
    if (p.chk_alu) chk("alu_result", bus.alu_result, p.alu);
    s_alu = bus.alu_result; s_npc = bus.npc; s_rdata = bus.r_data;
    s_we = bus.reg_we; s_halt = bus.is_halt;
    @(posedge clk);
    if (!rst) commit(ir_v, b);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rand_base();
    logic [31:0] off = 32'($urandom_range(0, 63));
    case ($urandom_range(0, 3))
      0, 1: return 32'h0000_0100 + off;
      2:    return 32'h8000_0100 + off;
      default: return 32'h0001_0100 + off;
    endcase
  endfunction

  task automatic rand_step();
    logic [31:0] r, ir_v, a, b, pc_v;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] mimm;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [6:0]  op;
    r    = $urandom;
    rd   = 5'($urandom_range(0, 31));
    r1   = 5'($urandom_range(0, 31));
    r2   = 5'($urandom_range(0, 31));
    f3   = 3'($urandom_range(0, 7));
    a    = rand_val();
    b    = rand_val();
    pc_v = $urandom & ~32'd3;
    mimm = 12'($urandom_range(0, 63) - 32);
    case ($urandom_range(0, 10))
      0: ir_v = enc_r($urandom_range(0, 1) != 0 ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'h33);
      1: ir_v = enc_i(r[11:0], r1, f3, rd, 7'h13);
      2: ir_v = {r[31:12], rd, 7'h37};
      3: ir_v = {r[31:12], rd, 7'h17};
      4: ir_v = enc_j({r[20:1], 1'b0}, rd);
      5: ir_v = enc_i(r[11:0], r1, 3'd0, rd, 7'h67);
      6: begin
        if ($urandom_range(0, 2) == 0) b = a;
        ir_v = enc_b({r[12:1], 1'b0}, r2, r1, br_f3[$urandom_range(0, 5)]);
      end
      7: begin a = rand_base(); ir_v = enc_i(mimm, r1, ld_f3[$urandom_range(0, 4)], rd, 7'h03); end
      8: begin a = rand_base(); ir_v = enc_s(mimm, r2, r1, 3'($urandom_range(0, 2))); end
      9: ir_v = {r[31:7], 7'h0F};
      default: begin
        op = 7'h37;
        while (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73})
          op = 7'($urandom_range(0, 127));
        ir_v = {r[31:7], op};
      end
    endcase
    step(ir_v, pc_v, a, b);
  endtask

  localparam logic [31:0] ADDI_M3 = 32'hFFD0_0293;

  initial begin
    bus.ir = 32'd0; bus.pc = 32'd0; bus.srcreg1_data = 32'd0; bus.srcreg2_data = 32'd0;

    // Reset held for two cycles
    step(ADDI_M3, 32'h100, 32'd0, 32'd0);
    step(ADDI_M3, 32'h100, 32'd0, 32'd0);
    rst = 1'b0;
    chk("reset_halted", 32'(bus.halted), 32'd0);

    step(ADDI_M3, 32'h100, 32'd0, 32'd0);
    chk("addi_we",  32'(s_we), 32'd1);
    chk("addi_alu", s_alu, 32'hFFFF_FFFD);
    chk("addi_npc", s_npc, 32'h104);

    step(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd4), 32'h40, 32'hFFFF_FFFF, 32'd1);
    chk("blt_npc", s_npc, 32'h38);
    step(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd6), 32'h40, 32'hFFFF_FFFF, 32'd1);
    chk("bltu_npc", s_npc, 32'h44);
    chk("bltu_we",  32'(s_we), 32'd0);

    step(enc_s(12'd0, 5'd2, 5'd1, 3'd2), 32'h0, 32'h10, 32'h80A1_B2C3);
    step(enc_i(12'd0, 5'd1, 3'd0, 5'd3, 7'h03), 32'h4, 32'h13, 32'd0);
    chk("lb_13", s_rdata, 32'hFFFF_FF80);
    step(enc_i(12'd0, 5'd1, 3'd4, 5'd3, 7'h03), 32'h8, 32'h11, 32'd0);
    chk("lbu_11", s_rdata, 32'h0000_00B2);
    step(enc_i(12'd0, 5'd1, 3'd1, 5'd3, 7'h03), 32'hC, 32'h12, 32'd0);
    chk("lh_12", s_rdata, 32'hFFFF_80A1);
    step(enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h10, 32'h10, 32'd0);
    chk("lw_10", s_rdata, 32'h80A1_B2C3);

    step(enc_s(12'd0, 5'd2, 5'd1, 3'd0), 32'h14, 32'h11, 32'hFFFF_FF55);
    step(enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h18, 32'h10, 32'd0);
    chk("sb_merge", s_rdata, 32'h80A1_55C3);

    step(enc_s(12'd0, 5'd2, 5'd1, 3'd2), 32'h1C, 32'hFFFF_FF00, 32'hDEAD_BEEF);
    step(enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h20, 32'h0000_FF00, 32'd0);
    chk("mmio_store", s_rdata, 32'd0);

    for (int i = 0; i < 3000; i++) rand_step();

    step(32'h0000_0073, 32'h200, 32'd0, 32'd0);
    chk("ecall_halt", 32'(s_halt), 32'd1);
    chk("ecall_npc",  s_npc, 32'h200);
    chk("ecall_flag", 32'(bus.halted), 32'd1);
    step(enc_s(12'd0, 5'd2, 5'd1, 3'd2), 32'h204, 32'h10, 32'h1234_5678);
    step(enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h208, 32'h10, 32'd0);
    chk("halted_store", s_rdata, 32'h80A1_55C3);
    step(ADDI_M3, 32'h20C, 32'd0, 32'd0);
    chk("halted_we",  32'(s_we), 32'd0);
    chk("halted_npc", s_npc, 32'h20C);

    #2 rst = 1'b1;
    halted_m = 1'b0;
    #1 chk("async_clear", 32'(bus.halted), 32'd0);
    rst = 1'b0;
    step(ADDI_M3, 32'h300, 32'd0, 32'd0);
    chk("post_rst_we",  32'(s_we), 32'd1);
    chk("post_rst_npc", s_npc, 32'h304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
